// File: rtl/dm_arbiter.sv
// Two-port (CPU / debug) arbiter in front of the data memory.
// One access at a time: IDLE -> ISSUE -> RESP, with anti-starvation for debug.
module dm_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_din,
  input  logic [2:0]  c_type,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_din,
  input  logic [2:0]  d_type,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic [2:0]  m_type,
  input  logic [31:0] m_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [2:0]  r_type;
  logic [31:0] r_c_rdata;
  logic [31:0] r_d_rdata;
  logic [3:0]  r_wait;
  logic        w_grant;
  logic        w_dbg_win;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_dbg_win = 1'b0;
    m_we      = 1'b0;
    c_ack     = 1'b0;
    d_ack     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_grant   = c_req | d_req;
        // Debug takes over once it has lost MAX_WAIT decisions in a row.
        w_dbg_win = d_req & (~c_req | (r_wait == LP_MAX));
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        m_we   = r_we;
        w_next = S_RESP;
      end
      S_RESP: begin
        c_ack  = ~r_owner;
        d_ack  = r_owner;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_type    <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
      r_wait    <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_grant) begin
          r_owner <= w_dbg_win;
          r_we    <= w_dbg_win ? d_we   : c_we;
          r_addr  <= w_dbg_win ? d_addr : c_addr;
          r_din   <= w_dbg_win ? d_din  : c_din;
          r_type  <= w_dbg_win ? d_type : c_type;
        end
        if (!d_req || w_dbg_win)  r_wait <= '0;
        else if (r_wait != LP_MAX) r_wait <= r_wait + 4'd1;
      end
      if (r_state == S_ISSUE) begin
        if (r_owner) r_d_rdata <= m_dout;
        else         r_c_rdata <= m_dout;
      end
    end
  end

  assign m_addr  = r_addr;
  assign m_din   = r_din;
  assign m_type  = r_type;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != S_IDLE);
  assign owner   = r_owner;

endmodule
